max_pool_2x2_stream: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of a multi-channel 3×3 convolution block. It consumes one channel's raster-ordered feature-map stream (`In`/`valid_in`) and emits the pooled map as a raster-ordered stream (`Out`/`valid_out`). One instance is placed per conv output channel. It buffers one half-row of partial maxima so that each output appears one cycle after the fourth pixel of its window.

---
 rtl/max_pool_2x2_stream_pkg.sv | 12 +
 rtl/pool_line_buffer.sv | 23 ++
 rtl/max_pool_2x2_stream.sv | 122 ++++++++++++
 tb/tb_max_pool_2x2_stream.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/max_pool_2x2_stream_pkg.sv
// rtl/max_pool_2x2_stream_pkg.sv - shared sizing helper for the 2x2 pooling stage
package max_pool_2x2_stream_pkg;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - half-row store of pair maxima, async read, no reset
module pool_line_buffer #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32,
   parameter int AW    = 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// rtl/max_pool_2x2_stream.sv - streaming 2x2 stride-2 max pooling with optional ReLU
module max_pool_2x2_stream
   import max_pool_2x2_stream_pkg::*;
#(
   parameter int IMG_Width  = 3,
   parameter int IMG_Height = 3,
   parameter int Datawidth  = 32,
   parameter int ReLU       = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic signed [Datawidth-1:0] In,
   output logic signed [Datawidth-1:0] Out,
   output logic                        valid_out,
   output logic                        frame_done
);

   localparam int PW = IMG_Width / 2;
   localparam int PH = IMG_Height / 2;
   localparam int CW = cnt_width(IMG_Width);
   localparam int RW = cnt_width(IMG_Height);
   localparam int LW = cnt_width(PW);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
   localparam logic [CW-1:0] COL_LAST_PAIR = CW'(2 * PW - 1);
   localparam logic [RW-1:0] ROW_LAST_PAIR = RW'(2 * PH - 1);

   function automatic logic signed [Datawidth-1:0] smax(
      input logic signed [Datawidth-1:0] a,
      input logic signed [Datawidth-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   logic [CW-1:0]                col_q, col_d;
   logic [RW-1:0]                row_q, row_d;
   logic signed [Datawidth-1:0]  hold_q, hold_d;
   logic signed [Datawidth-1:0]  out_q, out_d;
   logic                         valid_out_q, valid_out_d;
   logic                         frame_done_q, frame_done_d;

   logic                         lb_we;
   logic [LW-1:0]                lb_addr;
   logic signed [Datawidth-1:0]  lb_rdata;
   logic signed [Datawidth-1:0]  pair_max;
   logic signed [Datawidth-1:0]  win_max;
   logic signed [Datawidth-1:0]  result;
   logic                         in_window;

   assign lb_addr   = LW'(col_q >> 1);
   assign pair_max  = smax(hold_q, In);
   assign win_max   = smax(lb_rdata, pair_max);
   assign result    = (ReLU != 0 && win_max[Datawidth-1]) ? '0 : win_max;
   // Odd trailing column/row fall outside every window and are skipped.
   assign in_window = (32'(col_q) < 32'(2 * PW)) && (32'(row_q) < 32'(2 * PH));

   pool_line_buffer #(
      .DEPTH (PW),
      .WIDTH (Datawidth),
      .AW    (LW)
   ) u_line_buffer (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_addr),
      .wdata (pair_max),
      .raddr (lb_addr),
      .rdata (lb_rdata)
   );

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      out_d        = out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we        = 1'b0;
      if (valid_in) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         if (in_window) begin
            if (!col_q[0]) begin
               hold_d = In;
            end else if (!row_q[0]) begin
               lb_we = 1'b1;
            end else begin
               out_d        = result;
               valid_out_d  = 1'b1;
               frame_done_d = (col_q == COL_LAST_PAIR) && (row_q == ROW_LAST_PAIR);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         out_q        <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         out_q        <= out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign Out        = out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// tb/tb_max_pool_2x2_stream.sv - directed checks of 2x2 max pooling on three configurations
module tb_max_pool_2x2_stream;

   logic               clk;
   logic               rst;
   logic               valid_in;
   logic signed [31:0] din;
   logic signed [31:0] out_a, out_b, out_c;
   logic               vo_a, vo_b, vo_c;
   logic               fd_a, fd_b, fd_c;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int acc_q[$];
   int va[$], ca[$], fa[$];
   int vb[$], cb[$], fb[$];
   int vc[$], cc[$], fc[$];
   int ev[$], ep[$], ef[$];

   max_pool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .ReLU(0)) u_a (
      .clk(clk), .rst(rst), .valid_in(valid_in), .In(din),
      .Out(out_a), .valid_out(vo_a), .frame_done(fd_a));

   max_pool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .ReLU(1)) u_b (
      .clk(clk), .rst(rst), .valid_in(valid_in), .In(din),
      .Out(out_b), .valid_out(vo_b), .frame_done(fd_b));

   max_pool_2x2_stream #(.IMG_Width(5), .IMG_Height(3), .Datawidth(32), .ReLU(0)) u_c (
      .clk(clk), .rst(rst), .valid_in(valid_in), .In(din),
      .Out(out_c), .valid_out(vo_c), .frame_done(fd_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vo_a) begin va.push_back(int'(out_a)); ca.push_back(cyc); end
      if (fd_a) fa.push_back(cyc);
      if (vo_b) begin vb.push_back(int'(out_b)); cb.push_back(cyc); end
      if (fd_b) fb.push_back(cyc);
      if (vo_c) begin vc.push_back(int'(out_c)); cc.push_back(cyc); end
      if (fd_c) fc.push_back(cyc);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_all();
      acc_q.delete();
      va.delete(); ca.delete(); fa.delete();
      vb.delete(); cb.delete(); fb.delete();
      vc.delete(); cc.delete(); fc.delete();
      ev.delete(); ep.delete(); ef.delete();
   endtask

   // rst and valid_in overlap for one cycle; the pixel offered then must be dropped.
   task automatic do_reset(input bit check_outputs);
      @(negedge clk);
      rst = 1'b1; valid_in = 1'b1; din = 99;
      @(negedge clk);
      valid_in = 1'b0;
      if (check_outputs) begin
         check("rst_out_a", out_a, 0);   check("rst_vo_a", vo_a, 0);   check("rst_fd_a", fd_a, 0);
         check("rst_out_b", out_b, 0);   check("rst_vo_b", vo_b, 0);   check("rst_fd_b", fd_b, 0);
         check("rst_out_c", out_c, 0);   check("rst_vo_c", vo_c, 0);   check("rst_fd_c", fd_c, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_all();
   endtask

   task automatic send(input int v, input int gap);
      repeat (gap) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
      @(negedge clk);
      valid_in = 1'b1;
      din = v;
      acc_q.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic expect_out(input int v, input int px);
      ev.push_back(v);
      ep.push_back(px);
   endtask

   // Outputs carry the value, and must land in the cycle after the completing pixel (1-based index).
   task automatic check_stream(input string tag, input int sel);
      int gv[$], gc[$], gf[$];
      case (sel)
         0: begin gv = va; gc = ca; gf = fa; end
         1: begin gv = vb; gc = cb; gf = fb; end
         default: begin gv = vc; gc = cc; gf = fc; end
      endcase
      check({tag, "_count"}, gv.size(), ev.size());
      for (int i = 0; i < ev.size(); i++) begin
         if (i < gv.size()) begin
            check($sformatf("%s_val%0d", tag, i), gv[i], ev[i]);
            check($sformatf("%s_lat%0d", tag, i), gc[i], acc_q[ep[i] - 1]);
         end
      end
      check({tag, "_fd_count"}, gf.size(), ef.size());
      for (int i = 0; i < ef.size(); i++) begin
         if (i < gf.size())
            check($sformatf("%s_fd%0d", tag, i), gf[i], acc_q[ef[i] - 1]);
      end
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; din = 0;
      idle(2);
      do_reset(1'b1);

      // 4x4 ramp, continuous
      for (int i = 1; i <= 16; i++) send(i, 0);
      idle(4);
      expect_out(6, 6); expect_out(8, 8); expect_out(14, 14); expect_out(16, 16);
      ef.push_back(16);
      check_stream("ramp", 0);

      // negative ramp, with and without ReLU
      do_reset(1'b0);
      for (int i = 1; i <= 16; i++) send(-i, 0);
      idle(4);
      expect_out(-1, 6); expect_out(-3, 8); expect_out(-9, 14); expect_out(-11, 16);
      ef.push_back(16);
      check_stream("neg", 0);
      ev.delete(); ep.delete();
      expect_out(0, 6); expect_out(0, 8); expect_out(0, 14); expect_out(0, 16);
      check_stream("relu", 1);

      // 5x3: odd trailing column and row dropped
      do_reset(1'b0);
      for (int i = 1; i <= 15; i++) send(i, 0);
      idle(6);
      expect_out(7, 7); expect_out(9, 9);
      ef.push_back(9);
      check_stream("odd", 2);

      // random gaps in valid_in
      do_reset(1'b0);
      for (int i = 1; i <= 16; i++) send(i, int'($urandom_range(0, 3)));
      idle(4);
      expect_out(6, 6); expect_out(8, 8); expect_out(14, 14); expect_out(16, 16);
      ef.push_back(16);
      check_stream("gaps", 0);

      // back-to-back frames
      do_reset(1'b0);
      for (int i = 1; i <= 16; i++) send(i, 0);
      for (int i = 101; i <= 116; i++) send(i, 0);
      idle(4);
      expect_out(6, 6);    expect_out(8, 8);    expect_out(14, 14);  expect_out(16, 16);
      expect_out(106, 22); expect_out(108, 24); expect_out(114, 30); expect_out(116, 32);
      ef.push_back(16); ef.push_back(32);
      check_stream("b2b", 0);

      // reset mid-frame after pixel 7
      do_reset(1'b0);
      for (int i = 1; i <= 7; i++) send(i, 0);
      do_reset(1'b0);
      check("midrst_out_a", out_a, 0);
      for (int i = 1; i <= 16; i++) send(i, 0);
      idle(4);
      expect_out(6, 6); expect_out(8, 8); expect_out(14, 14); expect_out(16, 16);
      ef.push_back(16);
      check_stream("midrst", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
